// File: rtl/lp_serializer_feeder.sv
// Byte-pair packer feeding the 16:1 low-power tree serializer: small byte FIFO, one word per
// 16-cycle slot. Optional macro LP_FEEDER_PRBS_IDLE_EN replaces constant idle words with PRBS-15.
module lp_serializer_feeder #(
  parameter int unsigned       FIFO_DEPTH = 8,
  parameter int unsigned       WORD_W     = 16,
  parameter logic [WORD_W-1:0] IDLE_WORD  = 16'hBC50
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        EN,
  input  logic [7:0]                  IN_DATA,
  input  logic                        IN_VALID,
  output logic                        IN_READY,
  output logic [WORD_W-1:0]           PAR_OUT,
  output logic                        WORD_STROBE,
  output logic                        WORD_IS_IDLE,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);

  localparam int unsigned     PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned     LvlW  = PtrW + 1;
  localparam logic [LvlW-1:0] Depth = LvlW'(FIFO_DEPTH);

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
  logic [LvlW-1:0]   level_q, level_d;
  logic [3:0]        slot_q;
  logic [WORD_W-1:0] par_q, par_d, idle_word;
  logic              idle_q, idle_d, strobe_q;
  logic              boundary, push, pop;

  assign boundary   = (slot_q == 4'd15);
  assign IN_READY   = RESET_N && (level_q < Depth);
  assign push       = IN_VALID && IN_READY;
  // Eligibility uses the registered level, so a byte pushed on the boundary edge waits a word.
  assign pop        = boundary && EN && (level_q >= LvlW'(2));
  assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);

  always_comb begin
    level_d = level_q;
    if (push) level_d = level_d + LvlW'(1);
    if (pop)  level_d = level_d - LvlW'(2);
  end

  always_comb begin
    par_d  = par_q;
    idle_d = idle_q;
    if (boundary) begin
      if (pop) begin
        par_d  = {mem_q[rd_ptr_nxt], mem_q[rd_ptr_q]};
        idle_d = 1'b0;
      end else begin
        par_d  = idle_word;
        idle_d = 1'b1;
      end
    end
  end

`ifdef LP_FEEDER_PRBS_IDLE_EN
  logic [14:0] lfsr_q, lfsr_d;

  // x^15 + x^14 + 1, sixteen steps per idle word; bit 0 is the first step's output.
  always_comb begin
    lfsr_d    = lfsr_q;
    idle_word = '0;
    for (int i = 0; i < 16; i++) begin
      idle_word[i] = lfsr_d[14] ^ lfsr_d[13];
      lfsr_d       = {lfsr_d[13:0], idle_word[i]};
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      lfsr_q <= 15'h7FFF;
    end else if (boundary && !pop) begin
      lfsr_q <= lfsr_d;
    end
  end
`else
  assign idle_word = IDLE_WORD;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      slot_q   <= 4'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      par_q    <= IDLE_WORD;
      idle_q   <= 1'b1;
      strobe_q <= 1'b0;
    end else begin
      slot_q   <= slot_q + 4'd1;
      strobe_q <= boundary;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(2);
      level_q  <= level_d;
      par_q    <= par_d;
      idle_q   <= idle_d;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= IN_DATA;
  end

  assign PAR_OUT      = par_q;
  assign WORD_STROBE  = strobe_q;
  assign WORD_IS_IDLE = idle_q;
  assign FIFO_LEVEL   = level_q;

endmodule

// File: tb/tb_lp_serializer_feeder.sv
// Self-checking bench for lp_serializer_feeder: byte-queue reference model plus directed and
// randomized scenarios.
module tb_lp_serializer_feeder;

  localparam int          DEPTH = 8;
  localparam logic [15:0] IDLE  = 16'hBC50;

  logic        clk = 1'b0, rst_n = 1'b0, en = 1'b1, in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, word_strobe, word_is_idle;
  logic [15:0] par_out;
  logic [3:0]  fifo_level;

  lp_serializer_feeder #(.FIFO_DEPTH(DEPTH), .WORD_W(16), .IDLE_WORD(IDLE)) dut (
    .CLK(clk), .RESET_N(rst_n), .EN(en), .IN_DATA(in_data), .IN_VALID(in_valid),
    .IN_READY(in_ready), .PAR_OUT(par_out), .WORD_STROBE(word_strobe),
    .WORD_IS_IDLE(word_is_idle), .FIFO_LEVEL(fifo_level)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference model: a byte queue, a cycle-in-word count and the last word sent.
  logic [7:0]  q[$];
  logic [15:0] m_par;
  logic        m_idle, m_strobe;
  int          m_slot;

  function automatic logic [22:0] dut_vec();
    return {par_out, word_is_idle, word_strobe, fifo_level, in_ready};
  endfunction

  function automatic logic [22:0] model_vec();
    logic rdy;
    rdy = rst_n && (q.size() < DEPTH);
    return {m_par, m_idle, m_strobe, 4'(q.size()), rdy};
  endfunction

  task automatic model_reset();
    q.delete();
    m_par = IDLE; m_idle = 1'b1; m_strobe = 1'b0; m_slot = 0;
  endtask

  task automatic tick();
    logic bnd, pop, push;
    logic [7:0] d;
    bnd  = (m_slot == 15);
    push = in_valid && (q.size() < DEPTH);
    pop  = bnd && en && (q.size() >= 2);
    d    = in_data;
    @(posedge clk);
    if (bnd) begin
      if (pop) begin
        m_par = {q[1], q[0]};
        void'(q.pop_front());
        void'(q.pop_front());
        m_idle = 1'b0;
      end else begin
        m_par = IDLE; m_idle = 1'b1;
      end
    end
    if (push) q.push_back(d);
    m_strobe = bnd;
    m_slot = (m_slot + 1) % 16;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; en = 1'b1;
    #23;
    checks++;
    if (dut_vec() !== {IDLE, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL reset_values: got %h want %h", dut_vec(), {IDLE, 5'b10000});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 1; i <= 64; i++) begin
      tick();
      checks++;
      if ({par_out, word_is_idle, word_strobe} !== {IDLE, 1'b1, (i % 16 == 0)}) begin
        errors++;
        $display("FAIL idle_run cyc%0d: got %h/%b/%b want %h/1/%b", i, par_out, word_is_idle,
                 word_strobe, IDLE, (i % 16 == 0));
      end
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL idle_model cyc%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
  endtask

  task automatic test_pair();
    in_valid = 1'b1; in_data = 8'hA5; tick();
    in_data = 8'h3C; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !m_strobe; i++) begin
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL pair_model: got %h want %h", dut_vec(), model_vec());
      end
    end
    checks++;
    if ({par_out, word_is_idle, fifo_level} !== {16'h3CA5, 1'b0, 4'd0}) begin
      errors++; $display("FAIL pair_word: got %h/%b/%0d want 3ca5/0/0", par_out, word_is_idle,
                         fifo_level);
    end
    for (int i = 0; i < 16; i++) tick();
    checks++;
    if ({par_out, word_is_idle, word_strobe} !== {IDLE, 1'b1, 1'b1}) begin
      errors++; $display("FAIL pair_next_idle: got %h/%b/%b want %h/1/1", par_out, word_is_idle,
                         word_strobe, IDLE);
    end
  endtask

  task automatic test_single_byte();
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !m_strobe; i++) tick();
    checks++;
    if ({par_out, word_is_idle, fifo_level} !== {IDLE, 1'b1, 4'd1}) begin
      errors++; $display("FAIL single_held: got %h/%b/%0d want %h/1/1", par_out, word_is_idle,
                         fifo_level, IDLE);
    end
    in_valid = 1'b1; in_data = 8'h22; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !m_strobe; i++) tick();
    checks++;
    if ({par_out, word_is_idle, fifo_level} !== {16'h2211, 1'b0, 4'd0}) begin
      errors++; $display("FAIL single_paired: got %h/%b/%0d want 2211/0/0", par_out,
                         word_is_idle, fifo_level);
    end
  endtask

  task automatic test_fill_then_enable();
    int k, nb;
    logic pushed;
    en = 1'b0; in_valid = 1'b1; in_data = 8'h00;
    for (int i = 0; i < 40; i++) begin
      pushed = (q.size() < DEPTH);
      tick();
      if (pushed) in_data = in_data + 8'd1;
      checks++;
      if (dut_vec() !== model_vec() || (m_strobe && !word_is_idle)) begin
        errors++; $display("FAIL fill_model cyc%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    checks++;
    if ({fifo_level, in_ready, in_data} !== {4'd8, 1'b0, 8'd8}) begin
      errors++; $display("FAIL fill_full: got lvl=%0d rdy=%b pushed=%0d want 8/0/8", fifo_level,
                         in_ready, in_data);
    end
    en = 1'b1; k = 0; nb = 0;
    for (int i = 0; i < 80 && nb < 4; i++) begin
      pushed = (q.size() < DEPTH);
      tick();
      if (pushed) in_data = in_data + 8'd1;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL drain_model cyc%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      if (m_strobe) begin
        checks++;
        if ({par_out, word_is_idle} !== {8'(k + 1), 8'(k), 1'b0}) begin
          errors++; $display("FAIL drain_word%0d: got %h want %h", nb, par_out,
                             {8'(k + 1), 8'(k)});
        end
        k += 2; nb++;
      end
    end
    in_valid = 1'b0;
    for (int i = 0; i < 96; i++) tick();
    checks++;
    if (fifo_level !== 4'd0) begin
      errors++; $display("FAIL drain_empty: got %0d want 0", fifo_level);
    end
  endtask

  task automatic test_push_on_boundary();
    for (int i = 0; i < 16 && m_slot != 0; i++) tick();
    in_valid = 1'b1; in_data = 8'hA1; tick();
    in_data = 8'hB2; tick();
    in_valid = 1'b0;
    for (int i = 0; i < 16 && m_slot != 15; i++) tick();
    in_valid = 1'b1; in_data = 8'h77; tick();
    in_valid = 1'b0;
    checks++;
    if ({par_out, word_is_idle, word_strobe, fifo_level} !== {16'hB2A1, 1'b0, 1'b1, 4'd1}) begin
      errors++; $display("FAIL bnd_push_pop: got %h want %h", {par_out, word_is_idle,
                         word_strobe, fifo_level}, {16'hB2A1, 1'b0, 1'b1, 4'd1});
    end
    for (int i = 0; i < 16 && m_slot != 15; i++) tick();
    in_valid = 1'b1; in_data = 8'h88; tick();
    in_valid = 1'b0;
    checks++;
    if ({par_out, word_is_idle, fifo_level} !== {IDLE, 1'b1, 4'd2}) begin
      errors++; $display("FAIL bnd_push_not_eligible: got %h/%b/%0d want %h/1/2", par_out,
                         word_is_idle, fifo_level, IDLE);
    end
    for (int i = 0; i < 17; i++) begin
      tick();
      if (m_strobe) break;
    end
    checks++;
    if ({par_out, word_is_idle, fifo_level} !== {16'h8877, 1'b0, 4'd0}) begin
      errors++; $display("FAIL bnd_pair_later: got %h/%b/%0d want 8877/0/0", par_out,
                         word_is_idle, fifo_level);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      if ($urandom_range(0, 31) == 0) en = ~en;
      tick();
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++; $display("FAIL rand_model cyc%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    en = 1'b1; in_valid = 1'b0;
    for (int i = 0; i < 96; i++) tick();
    checks++;
    if (dut_vec() !== model_vec() || fifo_level !== 4'd0) begin
      errors++; $display("FAIL rand_drain: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_reset_midword();
    en = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(8'h40 + i);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 16 && m_slot != 7; i++) tick();
    checks++;
    if (fifo_level !== 4'd5) begin
      errors++; $display("FAIL mid_level5: got %0d want 5", fifo_level);
    end
    #2; rst_n = 1'b0; #1;
    checks++;
    if (dut_vec() !== {IDLE, 1'b1, 1'b0, 4'd0, 1'b0}) begin
      errors++; $display("FAIL mid_async_reset: got %h want %h", dut_vec(), {IDLE, 5'b10000});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; en = 1'b1;
    model_reset();
    for (int i = 1; i <= 16; i++) begin
      tick();
      checks++;
      if ({par_out, word_is_idle, word_strobe, fifo_level} !== {IDLE, 1'b1, (i == 16), 4'd0})
      begin
        errors++; $display("FAIL mid_after_release cyc%0d: got %h/%b/%b/%0d", i, par_out,
                           word_is_idle, word_strobe, fifo_level);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_single_byte();
    test_fill_then_enable();
    test_push_on_boundary();
    test_random();
    test_reset_midword();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
